// File: rtl/icache_ctrl_if.sv
// Fetch-side and refill-side signals of the instruction cache controller.
// master: pipeline fetch stage plus backing memory; slave: icache_ctrl.
interface icache_ctrl_if;
  logic [31:0] pc;
  logic        rd_en;
  logic [31:0] instr;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output pc, rd_en, mem_rdata, mem_ready,
    input  instr, hit, mem_req, mem_addr
  );

  modport slave (
    input  pc, rd_en, mem_rdata, mem_ready,
    output instr, hit, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational lookup, one-line-at-a-time refill FSM.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_ctrl #(
  parameter int LINES = 16,  // power of two, >= 2
  parameter int WORDS = 4    // power of two, >= 2
) (
  input  logic         clk,
  input  logic         rst,
  icache_ctrl_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_LSB = OFF_W + IDX_W + 2;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q, state_d;

  logic             valid_q  [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS];

  logic [31:0]      base_q;
  logic [OFF_W-1:0] cnt_q;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  logic tag_match;
  logic miss_start;
  logic word_accept;
  logic last_word;

  logic        hit_c;
  logic [31:0] instr_c;
  logic        mem_req_c;
  logic [31:0] mem_addr_c;

  assign pc_off   = bus.pc[OFF_W+1:2];
  assign pc_idx   = bus.pc[TAG_LSB-1:OFF_W+2];
  assign pc_tag   = bus.pc[31:TAG_LSB];
  assign fill_idx = base_q[TAG_LSB-1:OFF_W+2];
  assign fill_tag = base_q[31:TAG_LSB];

  assign tag_match   = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign miss_start  = (state_q == IDLE) && bus.rd_en && !tag_match;
  assign word_accept = (state_q == FILL) && bus.mem_ready;
  assign last_word   = (cnt_q == OFF_W'(WORDS - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.rd_en && !tag_match)      state_d = FILL;
      FILL:    if (bus.mem_ready && last_word)   state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  // Reset forces IDLE-style outputs immediately, even before the state register clears.
  always_comb begin
    hit_c      = 1'b0;
    instr_c    = '0;
    mem_req_c  = 1'b0;
    mem_addr_c = '0;
    if (rst) begin
      hit_c = !bus.rd_en;
    end else begin
      case (state_q)
        IDLE: begin
          hit_c = !bus.rd_en || tag_match;
          if (bus.rd_en && tag_match) instr_c = data_mem[pc_idx][pc_off];
        end
        FILL: begin
          mem_req_c  = 1'b1;
          mem_addr_c = base_q + 32'({cnt_q, 2'b00});
        end
        default: ;
      endcase
    end
  end

  assign bus.hit      = hit_c;
  assign bus.instr    = instr_c;
  assign bus.mem_req  = mem_req_c;
  assign bus.mem_addr = mem_addr_c;

  // The line is invalidated on miss so an aborted refill can never be seen as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) valid_q[i] <= 1'b0;
      base_q <= '0;
      cnt_q  <= '0;
    end else if (miss_start) begin
      base_q          <= {bus.pc[31:OFF_W+2], {(OFF_W+2){1'b0}}};
      cnt_q           <= '0;
      valid_q[pc_idx] <= 1'b0;
    end else if (word_accept) begin
      cnt_q <= cnt_q + OFF_W'(1);
      if (last_word) valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; valid_q alone decides whether their contents count.
  always_ff @(posedge clk) begin
    if (word_accept && !rst) begin
      data_mem[fill_idx][cnt_q] <= bus.mem_rdata;
      if (last_word) tag_mem[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if ((state_q == IDLE) && bus.rd_en && tag_match && (hit_count != '1))
        hit_count <= hit_count + 32'd1;
      if (miss_start && (miss_count != '1))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus random traffic against a line-level model.
module tb_icache_ctrl;
  localparam int LINES      = 16;
  localparam int WORDS      = 4;
  localparam int LINE_BYTES = WORDS * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_ctrl_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Backing memory: every word has a distinct address-derived value.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.mem_rdata = mem_fn(bus.mem_addr);

  int checks = 0;
  int errors = 0;

  // Reference model: which line base sits at each index, and progress of the pending refill.
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  bit          m_fill;
  logic [31:0] m_base;
  int          m_cnt;
  logic [31:0] m_hits, m_misses;

  logic        exp_hit, exp_req;
  logic [31:0] exp_instr, exp_addr;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LINE_BYTES - 1);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic bit present(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_line[idx_of(a)] == line_of(a));
  endfunction

  function automatic void predict();
    exp_hit = 1'b0; exp_instr = '0; exp_req = 1'b0; exp_addr = '0;
    if (rst) begin
      exp_hit = !bus.rd_en;
    end else if (m_fill) begin
      exp_req  = 1'b1;
      exp_addr = m_base + 32'(4 * m_cnt);
    end else begin
      exp_hit = !bus.rd_en || present(bus.pc);
      if (bus.rd_en && present(bus.pc)) exp_instr = mem_fn({bus.pc[31:2], 2'b00});
    end
  endfunction

  function automatic void model_update();
    if (rst) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_fill = 1'b0; m_cnt = 0; m_base = '0; m_hits = '0; m_misses = '0;
    end else if (m_fill) begin
      if (bus.mem_ready) begin
        m_cnt++;
        if (m_cnt == WORDS) begin
          m_valid[idx_of(m_base)] = 1'b1;
          m_line[idx_of(m_base)]  = m_base;
          m_fill = 1'b0;
        end
      end
    end else if (bus.rd_en) begin
      if (present(bus.pc)) begin
        if (m_hits != 32'hFFFF_FFFF) m_hits++;
      end else begin
        if (m_misses != 32'hFFFF_FFFF) m_misses++;
        m_fill = 1'b1; m_base = line_of(bus.pc); m_cnt = 0;
        m_valid[idx_of(bus.pc)] = 1'b0;
      end
    end
  endfunction

  task automatic apply(input logic [31:0] a_pc, input logic a_rd, input logic a_rdy, input logic a_rst);
    @(negedge clk);
    bus.pc = a_pc; bus.rd_en = a_rd; bus.mem_ready = a_rdy; rst = a_rst;
    #1;
    predict();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  // Requests pc with mem_ready=1 until hit; returns the number of non-hit cycles, -1 if the budget runs out.
  task automatic wait_hit(input logic [31:0] a_pc, output int n);
    n = -1;
    for (int c = 0; c < 20; c++) begin
      apply(a_pc, 1'b1, 1'b1, 1'b0);
      if (bus.hit === 1'b1) begin n = c; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    apply(32'h40, 1'b1, 1'b1, 1'b1); tick();
    apply(32'h40, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.hit !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd1: got hit=%b req=%b addr=%h instr=%h expected 0/0/0/0",
               bus.hit, bus.mem_req, bus.mem_addr, bus.instr);
    end
    tick();
    apply(32'h40, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.hit !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_rd0: got hit=%b req=%b expected 1/0", bus.hit, bus.mem_req);
    end
    tick();
  endtask

  task automatic test_cold_fill();
    for (int c = 0; c < 6; c++) begin
      apply(32'h40, 1'b1, 1'b1, 1'b0);
      checks++;
      if (c == 0) begin
        if (bus.hit !== 1'b0 || bus.mem_req !== 1'b0) begin
          errors++;
          $display("FAIL cold_miss: got hit=%b req=%b expected 0/0", bus.hit, bus.mem_req);
        end
      end else if (c < 5) begin
        if (bus.hit !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h3C + 32'(4 * c)) begin
          errors++;
          $display("FAIL cold_addr%0d: got hit=%b req=%b addr=%h expected 0/1/%h",
                   c, bus.hit, bus.mem_req, bus.mem_addr, 32'h3C + 32'(4 * c));
        end
      end else begin
        if (bus.hit !== 1'b1 || bus.instr !== mem_fn(32'h40) || bus.mem_req !== 1'b0) begin
          errors++;
          $display("FAIL cold_hit: got hit=%b instr=%h req=%b expected 1/%h/0",
                   bus.hit, bus.instr, bus.mem_req, mem_fn(32'h40));
        end
      end
      tick();
    end
  endtask

  task automatic test_warm();
    logic [31:0] pcs [4] = '{32'h44, 32'h48, 32'h4C, 32'h40};
    foreach (pcs[i]) begin
      apply(pcs[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.hit !== 1'b1 || bus.instr !== mem_fn(pcs[i]) || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL warm_%h: got hit=%b instr=%h req=%b expected 1/%h/0",
                 pcs[i], bus.hit, bus.instr, bus.mem_req, mem_fn(pcs[i]));
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    int n;
    apply(32'h140, 1'b1, 1'b1, 1'b0); tick();
    apply(32'h140, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h140) begin
      errors++;
      $display("FAIL conflict_refill_addr: got req=%b addr=%h expected 1/00000140", bus.mem_req, bus.mem_addr);
    end
    tick();
    wait_hit(32'h140, n);
    checks++;
    if (n !== 3 || bus.instr !== mem_fn(32'h140)) begin
      errors++;
      $display("FAIL conflict_fill: got wait=%0d instr=%h expected 3/%h", n, bus.instr, mem_fn(32'h140));
    end
    tick();
    wait_hit(32'h40, n);
    checks++;
    if (n !== 5 || bus.instr !== mem_fn(32'h40)) begin
      errors++;
      $display("FAIL conflict_evicted: got wait=%0d instr=%h expected 5/%h", n, bus.instr, mem_fn(32'h40));
    end
    tick();
  endtask

  task automatic test_ready_toggle();
    logic        rdy   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] addrs [6] = '{32'h200, 32'h204, 32'h204, 32'h204, 32'h208, 32'h20C};
    apply(32'h200, 1'b1, 1'b1, 1'b0); tick();
    for (int c = 0; c < 6; c++) begin
      apply(32'h200, 1'b1, rdy[c], 1'b0);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== addrs[c] || bus.hit !== 1'b0) begin
        errors++;
        $display("FAIL toggle_addr%0d: got req=%b addr=%h hit=%b expected 1/%h/0",
                 c, bus.mem_req, bus.mem_addr, bus.hit, addrs[c]);
      end
      tick();
    end
    for (int w = 0; w < WORDS; w++) begin
      apply(32'h200 + 32'(4 * w), 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.hit !== 1'b1 || bus.instr !== mem_fn(32'h200 + 32'(4 * w))) begin
        errors++;
        $display("FAIL toggle_word%0d: got hit=%b instr=%h expected 1/%h",
                 w, bus.hit, bus.instr, mem_fn(32'h200 + 32'(4 * w)));
      end
      tick();
    end
  endtask

  task automatic test_reset_during_fill();
    int words;
    apply(32'h380, 1'b1, 1'b1, 1'b0); tick();
    apply(32'h380, 1'b1, 1'b1, 1'b0); tick();
    apply(32'h380, 1'b1, 1'b1, 1'b0); tick();
    apply(32'h380, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.hit !== 1'b0) begin
      errors++;
      $display("FAIL abort_during_rst: got req=%b addr=%h hit=%b expected 0/0/0", bus.mem_req, bus.mem_addr, bus.hit);
    end
    tick();
    apply(32'h380, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.hit !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_line_invalid: got hit=%b req=%b expected 0/0", bus.hit, bus.mem_req);
    end
    tick();
    words = 0;
    for (int c = 0; c < 10; c++) begin
      apply(32'h380, 1'b1, 1'b1, 1'b0);
      if (bus.mem_req !== 1'b1) break;
      if (bus.mem_addr === 32'h380 + 32'(4 * words)) words++;
      tick();
    end
    checks++;
    if (words !== 4 || bus.hit !== 1'b1 || bus.instr !== mem_fn(32'h380)) begin
      errors++;
      $display("FAIL abort_refill: got words=%0d hit=%b instr=%h expected 4/1/%h",
               words, bus.hit, bus.instr, mem_fn(32'h380));
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      apply(32'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 149) == 0));
      checks++;
      if (bus.hit !== exp_hit || bus.instr !== exp_instr || bus.mem_req !== exp_req || bus.mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL random_c%0d pc=%h: got hit=%b instr=%h req=%b addr=%h expected %b/%h/%b/%h",
                 c, bus.pc, bus.hit, bus.instr, bus.mem_req, bus.mem_addr, exp_hit, exp_instr, exp_req, exp_addr);
      end
`ifdef ICACHE_STATS_EN
      checks++;
      if (hit_count !== m_hits || miss_count !== m_misses) begin
        errors++;
        $display("FAIL random_stats_c%0d: got hits=%0d misses=%0d expected %0d/%0d",
                 c, hit_count, miss_count, m_hits, m_misses);
      end
`endif
      tick();
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    int n;
    apply(32'h0, 1'b0, 1'b0, 1'b1); tick();
    wait_hit(32'h600, n);
    tick();
    apply(32'h604, 1'b0, 1'b0, 1'b0); tick();
    apply(32'h604, 1'b1, 1'b0, 1'b0); tick();
    apply(32'h608, 1'b0, 1'b1, 1'b0); tick();
    apply(32'h608, 1'b1, 1'b0, 1'b0); tick();
    apply(32'h60C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n !== 5 || miss_count !== 32'd1 || hit_count !== 32'd3) begin
      errors++;
      $display("FAIL stats_counts: got wait=%0d misses=%0d hits=%0d expected 5/1/3", n, miss_count, hit_count);
    end
    tick();
  endtask
`endif

  initial begin
    bus.pc = '0; bus.rd_en = 1'b0; bus.mem_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_cold_fill();
    test_warm();
    test_conflict();
    test_ready_toggle();
    test_reset_during_fill();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
